// File: rtl/serial_rx_demux.sv
// -----------------------------------------------------------------------------
// serial_rx_demux
//
// Purpose:
//   Recovers byte alignment on a 1-bit serial line (MSB first) using a COMMA
//   idle symbol. After SYNC_COUNT consecutive aligned COMMA bytes the receiver
//   locks. While locked, each non-COMMA byte is written round-robin into one of
//   four output lanes. COMMA bytes inside a locked stream only raise idle_out.
//
// Ports:
//   clk_32f          in   1  bit clock, one serial bit per cycle
//   reset            in   1  synchronous, active-high
//   in_serial        in   1  serial data, MSB of each byte first
//   data_out0..3     out  8  lane data, held until the lane is next written
//   valid_out0..3    out  1  one-cycle pulse when the matching lane is written
//   active           out  1  high while LOCKED
//   idle_out         out  1  high while the last locked byte was COMMA
//   byte_out         out  8  last aligned byte seen (any state)
//   byte_valid       out  1  one-cycle pulse per aligned byte boundary
//
// State table:
//   HUNT   | searching every cycle for COMMA at any bit offset
//   SYNC   | aligned, counting consecutive COMMA bytes toward lock
//   LOCKED | demultiplexing data bytes into lanes; left only by reset
// -----------------------------------------------------------------------------
module serial_rx_demux #(
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         SYNC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       in_serial,
  output logic [7:0] data_out0,
  output logic [7:0] data_out1,
  output logic [7:0] data_out2,
  output logic [7:0] data_out3,
  output logic       valid_out0,
  output logic       valid_out1,
  output logic       valid_out2,
  output logic       valid_out3,
  output logic       active,
  output logic       idle_out,
  output logic [7:0] byte_out,
  output logic       byte_valid
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Wide enough to hold comma_cnt + 1 without wrapping.
  localparam int CW = $clog2(SYNC_COUNT + 2);

  state_t            state_q, state_d;
  logic [7:0]        sr_q, sr_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]     comma_cnt_q, comma_cnt_d;
  logic [CW-1:0]     comma_inc;
  logic [1:0]        lane_sel_q, lane_sel_d;
  logic [3:0][7:0]   data_q, data_d;
  logic [3:0]        valid_q, valid_d;
  logic              idle_q, idle_d;
  logic [7:0]        byte_out_q, byte_out_d;
  logic              byte_valid_q, byte_valid_d;

  logic is_comma;
  logic boundary;

  assign is_comma  = (sr_q == COMMA);
  // Once aligned, bit_cnt == 7 marks the cycle in which sr holds a full byte.
  assign boundary  = (state_q != HUNT) && (bit_cnt_q == 3'd7);
  assign comma_inc = comma_cnt_q + 1'b1;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT: begin
        if (is_comma) begin
          state_d = (SYNC_COUNT <= 1) ? LOCKED : SYNC;
        end
      end
      SYNC: begin
        if (boundary) begin
          if (!is_comma) begin
            state_d = HUNT;
          end else if (int'(comma_inc) >= SYNC_COUNT) begin
            state_d = LOCKED;
          end
        end
      end
      LOCKED:  state_d = LOCKED;
      default: state_d = HUNT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next-value logic
  // ---------------------------------------------------------------------------
  always_comb begin
    sr_d         = {sr_q[6:0], in_serial};
    bit_cnt_d    = bit_cnt_q + 3'd1;
    comma_cnt_d  = comma_cnt_q;
    lane_sel_d   = lane_sel_q;
    data_d       = data_q;
    valid_d      = '0;
    idle_d       = idle_q;
    byte_out_d   = byte_out_q;
    byte_valid_d = 1'b0;

    case (state_q)
      HUNT: begin
        // Counter parks at 0 so the next boundary lands exactly 8 cycles
        // after the comma that fixed alignment.
        bit_cnt_d = 3'd0;
        if (is_comma) begin
          comma_cnt_d  = CW'(1);
          byte_out_d   = sr_q;
          byte_valid_d = 1'b1;
        end else begin
          comma_cnt_d  = '0;
        end
      end
      SYNC: begin
        if (boundary) begin
          byte_out_d   = sr_q;
          byte_valid_d = 1'b1;
          comma_cnt_d  = is_comma ? comma_inc : '0;
        end
      end
      LOCKED: begin
        if (boundary) begin
          byte_out_d   = sr_q;
          byte_valid_d = 1'b1;
          if (is_comma) begin
            idle_d = 1'b1;
          end else begin
            data_d[lane_sel_q]  = sr_q;
            valid_d[lane_sel_q] = 1'b1;
            idle_d              = 1'b0;
            lane_sel_d          = lane_sel_q + 2'd1;
          end
        end
      end
      default: begin
        bit_cnt_d   = 3'd0;
        comma_cnt_d = '0;
      end
    endcase

    // First data byte after any lock always lands in lane 0.
    if ((state_d == LOCKED) && (state_q != LOCKED)) begin
      lane_sel_d = 2'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      comma_cnt_q  <= '0;
      lane_sel_q   <= '0;
      data_q       <= '0;
      valid_q      <= '0;
      idle_q       <= 1'b0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      comma_cnt_q  <= comma_cnt_d;
      lane_sel_q   <= lane_sel_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      idle_q       <= idle_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
    end
  end

  assign data_out0  = data_q[0];
  assign data_out1  = data_q[1];
  assign data_out2  = data_q[2];
  assign data_out3  = data_q[3];
  assign valid_out0 = valid_q[0];
  assign valid_out1 = valid_q[1];
  assign valid_out2 = valid_q[2];
  assign valid_out3 = valid_q[3];
  assign active     = (state_q == LOCKED);
  assign idle_out   = idle_q;
  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;

endmodule

// File: tb/tb_serial_rx_demux.sv
module tb_serial_rx_demux;

  logic       clk_32f = 1'b0;
  logic       reset = 1'b0;
  logic       in_serial = 1'b0;
  logic [7:0] data_out0, data_out1, data_out2, data_out3;
  logic       valid_out0, valid_out1, valid_out2, valid_out3;
  logic       active, idle_out, byte_valid;
  logic [7:0] byte_out;

  serial_rx_demux dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .in_serial  (in_serial),
    .data_out0  (data_out0),
    .data_out1  (data_out1),
    .data_out2  (data_out2),
    .data_out3  (data_out3),
    .valid_out0 (valid_out0),
    .valid_out1 (valid_out1),
    .valid_out2 (valid_out2),
    .valid_out3 (valid_out3),
    .active     (active),
    .idle_out   (idle_out),
    .byte_out   (byte_out),
    .byte_valid (byte_valid)
  );

  always #5 clk_32f = ~clk_32f;

  // One record = one transmitted byte and what the outputs must show
  // one cycle after its boundary.
  typedef struct {
    bit         do_rst;
    int         npre;
    logic [7:0] pre;
    logic [7:0] tx;
    bit         e_act;
    logic [3:0] e_valid;
    logic [7:0] e_data;
    bit         e_idle;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] lane_model [4];
  vec_t       pv;
  int         pv_idx;
  bit         pend = 1'b0;
  int         since = 0;
  vec_t       tbl [$];

  wire [3:0] vmask = {valid_out3, valid_out2, valid_out1, valid_out0};

  function automatic vec_t mk(bit r, int np, logic [7:0] pre, logic [7:0] tx,
                              bit act, logic [3:0] v, logic [7:0] d, bit idl);
    vec_t x;
    x.do_rst = r; x.npre = np; x.pre = pre; x.tx = tx;
    x.e_act = act; x.e_valid = v; x.e_data = d; x.e_idle = idl;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act_v, exp_v);
    end
  endtask

  task automatic check_pending();
    string p;
    p = $sformatf("rec%0d", pv_idx);
    for (int i = 0; i < 4; i++) if (pv.e_valid[i]) lane_model[i] = pv.e_data;
    chk({p, " active"},     32'(active),     32'(pv.e_act));
    chk({p, " valid"},      32'(vmask),      32'(pv.e_valid));
    chk({p, " idle_out"},   32'(idle_out),   32'(pv.e_idle));
    chk({p, " byte_valid"}, 32'(byte_valid), 32'd1);
    chk({p, " byte_out"},   32'(byte_out),   32'(pv.tx));
    chk({p, " data_out0"},  32'(data_out0),  32'(lane_model[0]));
    chk({p, " data_out1"},  32'(data_out1),  32'(lane_model[1]));
    chk({p, " data_out2"},  32'(data_out2),  32'(lane_model[2]));
    chk({p, " data_out3"},  32'(data_out3),  32'(lane_model[3]));
  endtask

  // Drives one bit on the falling edge; a pending byte is checked on the
  // second falling edge after its last bit (boundary cycle + 1 edge).
  task automatic drive_bit(input logic b);
    @(negedge clk_32f);
    if (pend) begin
      since++;
      if (since == 2) begin
        check_pending();
        pend = 1'b0;
      end
    end
    in_serial = b;
  endtask

  task automatic settle();
    while (pend) drive_bit(1'b0);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, " active"},     32'(active),     32'd0);
    chk({nm, " valid"},      32'(vmask),      32'd0);
    chk({nm, " idle_out"},   32'(idle_out),   32'd0);
    chk({nm, " byte_valid"}, 32'(byte_valid), 32'd0);
    chk({nm, " byte_out"},   32'(byte_out),   32'd0);
    chk({nm, " data_out"},   {data_out3, data_out2, data_out1, data_out0}, 32'd0);
  endtask

  task automatic do_reset();
    settle();
    reset = 1'b1;
    drive_bit(1'b0);
    drive_bit(1'b0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) lane_model[i] = 8'h00;
  endtask

  task automatic send_rec(input vec_t v, input int idx);
    if (v.do_rst) do_reset();
    for (int i = v.npre - 1; i >= 0; i--) drive_bit(v.pre[i]);
    for (int i = 7; i >= 0; i--) drive_bit(v.tx[i]);
    pv = v;
    pv_idx = idx;
    pend = 1'b1;
    since = 0;
  endtask

  // Valid pulses: never two lanes at once, never closer than 8 cycles.
  int cyc = 0;
  int last_v = -100;
  always @(negedge clk_32f) begin
    cyc++;
    if (|vmask) begin
      checks++;
      if (!$onehot(vmask)) begin
        errors++;
        $display("FAIL valid_onehot: got %b expected one-hot", vmask);
      end
      checks++;
      if (cyc - last_v < 8) begin
        errors++;
        $display("FAIL valid_spacing: got %0d cycles expected >= 8", cyc - last_v);
      end
      last_v = cyc;
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) lane_model[i] = 8'h00;

    // Lock and round-robin, wrap, idle in stream
    tbl.push_back(mk(1, 0, 8'h00, 8'hBC, 0, 4'b0000, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hBC, 0, 4'b0000, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hBC, 0, 4'b0000, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hBC, 1, 4'b0000, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h11, 1, 4'b0001, 8'h11, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h22, 1, 4'b0010, 8'h22, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h33, 1, 4'b0100, 8'h33, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h44, 1, 4'b1000, 8'h44, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h55, 1, 4'b0001, 8'h55, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hBC, 1, 4'b0000, 8'h00, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h66, 1, 4'b0010, 8'h66, 0));
    // Broken sync after two commas
    tbl.push_back(mk(1, 0, 8'h00, 8'hBC, 0, 4'b0000, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hBC, 0, 4'b0000, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h12, 0, 4'b0000, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hBC, 0, 4'b0000, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hBC, 0, 4'b0000, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hBC, 0, 4'b0000, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hBC, 1, 4'b0000, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h34, 1, 4'b0001, 8'h34, 0));
    // Idle between data bytes right after lock
    tbl.push_back(mk(1, 0, 8'h00, 8'hBC, 0, 4'b0000, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hBC, 0, 4'b0000, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hBC, 0, 4'b0000, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hBC, 1, 4'b0000, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'h01, 1, 4'b0001, 8'h01, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hBC, 1, 4'b0000, 8'h00, 1));
    tbl.push_back(mk(0, 0, 8'h00, 8'h02, 1, 4'b0010, 8'h02, 0));
    // Three-bit offset before the first comma
    tbl.push_back(mk(1, 3, 8'h05, 8'hBC, 0, 4'b0000, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hBC, 0, 4'b0000, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hBC, 0, 4'b0000, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hBC, 1, 4'b0000, 8'h00, 0));
    tbl.push_back(mk(0, 0, 8'h00, 8'hA5, 1, 4'b0001, 8'hA5, 0));

    do_reset();
    check_zero("reset_state");

    for (int i = 0; i < tbl.size(); i++) send_rec(tbl[i], i);
    settle();

    // Reset three bits into a data byte while locked
    send_rec(mk(1, 0, 8'h00, 8'hBC, 0, 4'b0000, 8'h00, 0), 100);
    send_rec(mk(0, 0, 8'h00, 8'hBC, 0, 4'b0000, 8'h00, 0), 101);
    send_rec(mk(0, 0, 8'h00, 8'hBC, 0, 4'b0000, 8'h00, 0), 102);
    send_rec(mk(0, 0, 8'h00, 8'hBC, 1, 4'b0000, 8'h00, 0), 103);
    send_rec(mk(0, 0, 8'h00, 8'h11, 1, 4'b0001, 8'h11, 0), 104);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    reset = 1'b1;
    drive_bit(1'b0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) lane_model[i] = 8'h00;
    check_zero("midbyte_reset");

    // Three commas are not enough to relock; four fresh ones are
    send_rec(mk(0, 0, 8'h00, 8'hBC, 0, 4'b0000, 8'h00, 0), 110);
    send_rec(mk(0, 0, 8'h00, 8'hBC, 0, 4'b0000, 8'h00, 0), 111);
    send_rec(mk(0, 0, 8'h00, 8'hBC, 0, 4'b0000, 8'h00, 0), 112);
    send_rec(mk(0, 0, 8'h00, 8'h77, 0, 4'b0000, 8'h00, 0), 113);
    send_rec(mk(0, 0, 8'h00, 8'hBC, 0, 4'b0000, 8'h00, 0), 114);
    send_rec(mk(0, 0, 8'h00, 8'hBC, 0, 4'b0000, 8'h00, 0), 115);
    send_rec(mk(0, 0, 8'h00, 8'hBC, 0, 4'b0000, 8'h00, 0), 116);
    send_rec(mk(0, 0, 8'h00, 8'hBC, 1, 4'b0000, 8'h00, 0), 117);
    send_rec(mk(0, 0, 8'h00, 8'h78, 1, 4'b0001, 8'h78, 0), 118);
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_rx_demux.md
SERIAL_RX_DEMUX -- requirements
Module: serial_rx_demux

Interface
REQ-001 The block SHALL have exactly one clock, clk_32f; reset is synchronous and active-high, port name reset; all state SHALL update only on the rising edge of clk_32f.
REQ-002 Parameter COMMA, default 8'hBC, SHALL be the idle/alignment symbol the transmitter sends while no lane data is valid.
REQ-003 Parameter SYNC_COUNT, default 4, SHALL be the number of consecutive aligned COMMA bytes required before lock.
REQ-004 Ports SHALL be:
- clk_32f  input  1  bit clock, one serial bit per cycle
- reset  input  1  synchronous, active-high
- in_serial  input  1  serial line, MSB of each byte first
- data_out0..data_out3  output  8 each  lane data, held until the lane is next written
- valid_out0..valid_out3  output  1 each  one-cycle pulse when the matching data_out is updated
- active  output  1  high while LOCKED
- idle_out  output  1  high while the most recent locked byte was COMMA
- byte_out  output  8  last aligned byte received, any state
- byte_valid  output  1  one-cycle pulse per aligned byte boundary

Function
REQ-005 An 8-bit shift register SHALL shift in in_serial every cycle as {sr[6:0], in_serial}, including in HUNT.
REQ-006 FSM states SHALL be HUNT, SYNC and LOCKED; reset SHALL select HUNT.
REQ-007 HUNT: on the first cycle sr == COMMA, the block SHALL fix byte alignment so that the next boundary falls exactly 8 cycles later, load comma_cnt = 1 and go to SYNC. sr SHALL be compared every cycle, so any bit offset is acquired.
REQ-008 A 3-bit bit counter SHALL wrap 7->0 after alignment. Each wrap is a byte boundary, and sr at that cycle is the aligned byte.
REQ-009 SYNC, boundary byte == COMMA: comma_cnt SHALL increment. When it reaches SYNC_COUNT, the FSM SHALL go to LOCKED, and active SHALL be 1 from the next cycle.
REQ-010 SYNC, boundary byte != COMMA: the FSM SHALL return to HUNT with comma_cnt = 0. The same sr value SHALL NOT be re-checked for a comma in that cycle.
REQ-011 LOCKED, boundary byte == COMMA: idle_out SHALL be set to 1, and no valid_outN SHALL pulse.
REQ-012 LOCKED, boundary byte != COMMA: the block SHALL write the byte to data_out[lane_sel], pulse valid_out[lane_sel] for one cycle, clear idle_out and advance lane_sel (2 bits) mod 4, wrapping 3->0.
REQ-013 lane_sel SHALL reset to 0 on every entry to LOCKED, so the first data byte after lock always goes to lane 0.
REQ-014 Latency: outputs SHALL update at the clock edge after the boundary cycle (1 cycle after the last bit is sampled); byte_valid and byte_out SHALL update at the same edge.
REQ-015 At most one valid_outN SHALL be high in any cycle; valid pulses SHALL be at least 8 cycles apart.
REQ-016 LOCKED SHALL be left only by reset; COMMA bytes inside a locked stream do not change state.
REQ-017 data_outN SHALL hold its value between writes; non-written lanes SHALL be unaffected.

Reset
REQ-018 While reset = 1 at a clock edge, at the next edge the block SHALL clear: sr = 0, bit counter = 0, comma_cnt = 0, lane_sel = 0, FSM = HUNT, data_out0..3 = 8'h00, valid_out0..3 = 0, active = 0, idle_out = 0, byte_out = 8'h00, byte_valid = 0.
REQ-019 Reset asserted mid-byte or while LOCKED SHALL discard partial bits, and realignment SHALL restart from HUNT.
REQ-020 Reset SHALL take priority over every simultaneous event.

Verification
REQ-021 Lock: after reset, send 4x 8'hBC then 8'h11, 8'h22, 8'h33, 8'h44, 8'h55 -> active = 1 after the 4th BC boundary; lanes 0..3 = 11, 22, 33, 44, each with a single valid pulse 8 cycles apart; 8'h55 goes to lane 0 (wrap).
REQ-022 Bit offset: send 3 random bits, then 4x BC and 8'hA5 -> lock is acquired, and data_out0 = 8'hA5 one cycle after its last bit.
REQ-023 Broken sync: send BC, BC, 8'h12, then 4x BC and 8'h34 -> no lock after the 8'h12 (return to HUNT); lock after the later 4 BCs; data_out0 = 8'h34.
REQ-024 Idle in stream: LOCKED; send 8'h01, BC, 8'h02 -> lane0 = 01, idle_out = 1 during BC, lane1 = 02, no valid pulse for the BC.
REQ-025 Mid-operation reset: assert reset for 1 cycle 3 bits into a data byte while LOCKED -> all outputs 0 next cycle, active = 0; relock requires 4 fresh BCs.
